// File: rtl/bp_counter_snapshot_drain.sv
// Captures a bank of live counters into a shadow bank on request and drains it
// as a valid/ready stream of (idx, data, seq) beats.
module bp_counter_snapshot_drain #(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 22
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p*width_p-1:0]   counters_i,
  input  logic                       snapshot_v_i,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(els_p)-1:0]   idx_o,
  output logic [7:0]                 seq_o,
  output logic                       last_o,
  output logic                       busy_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int unsigned idx_w_lp = $clog2(els_p);
  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(els_p - 1);

  localparam logic IDLE  = 1'b0;
  localparam logic DRAIN = 1'b1;

  logic                state_q, state_n;
  logic [idx_w_lp-1:0] idx_q, idx_n, idx_inc;
  logic [7:0]          seq_q, seq_n;
  logic [7:0]          drop_q, drop_n;
  logic [width_p-1:0]  data_q, data_n;
  logic                last_q, last_n;
  logic                capture;
  logic                hs;

  logic [width_p-1:0]  shadow_q [els_p];

  assign hs      = (state_q == DRAIN) && ready_i;
  assign idx_inc = idx_q + idx_w_lp'(1);

  // Next-state and output-register logic
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    seq_n   = seq_q;
    drop_n  = drop_q;
    data_n  = data_q;
    last_n  = last_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (snapshot_v_i) capture = 1'b1;
      end
      DRAIN: begin
        if (hs && last_q) begin
          if (snapshot_v_i) begin
            capture = 1'b1;
          end else begin
            state_n = IDLE;
            last_n  = 1'b0;
          end
        end else begin
          if (hs) begin
            idx_n  = idx_inc;
            data_n = shadow_q[idx_inc];
            last_n = (idx_inc == last_idx_lp);
          end
          if (snapshot_v_i && (drop_q != 8'hFF)) drop_n = drop_q + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Beat 0 comes straight from the live bank since the shadow is written on the same edge
    if (capture) begin
      state_n = DRAIN;
      idx_n   = '0;
      seq_n   = seq_q + 8'd1;
      data_n  = counters_i[width_p-1:0];
      last_n  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      seq_q   <= seq_n;
      drop_q  <= drop_n;
      data_q  <= data_n;
      last_q  <= last_n;
    end
  end

  // Shadow bank carries no reset; it is only read after a capture
  always_ff @(posedge clk_i) begin
    if (capture) begin
      for (int k = 0; k < int'(els_p); k++) begin
        shadow_q[k] <= counters_i[k*width_p +: width_p];
      end
    end
  end

  assign v_o        = (state_q == DRAIN);
  assign busy_o     = (state_q == DRAIN);
  assign data_o     = data_q;
  assign idx_o      = idx_q;
  assign seq_o      = seq_q;
  assign last_o     = last_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_bp_counter_snapshot_drain.sv
// Directed testbench for bp_counter_snapshot_drain with els_p=22, width_p=32.
module tb_bp_counter_snapshot_drain;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 22;
  localparam int unsigned IW = 5;

  logic           clk = 1'b0;
  logic           run = 1'b1;
  logic           reset_n = 1'b0;
  logic [N*W-1:0] counters = '0;
  logic           snapshot = 1'b0;
  logic           ready = 1'b0;
  logic           v_o, last_o, busy_o;
  logic [W-1:0]   data_o;
  logic [IW-1:0]  idx_o;
  logic [7:0]     seq_o, drop_cnt_o;

  int errors = 0;
  int checks = 0;

  bp_counter_snapshot_drain #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .counters_i(counters),
    .snapshot_v_i(snapshot), .v_o(v_o), .ready_i(ready), .data_o(data_o),
    .idx_o(idx_o), .seq_o(seq_o), .last_o(last_o), .busy_o(busy_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_counters(input int unsigned mul, input int unsigned add);
    for (int k = 0; k < int'(N); k++) counters[k*W +: W] = W'(mul * k + add);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({v_o, busy_o, last_o, idx_o, seq_o, drop_cnt_o, data_o} !== '0) begin
      errors++;
      $display("FAIL %s: v=%b busy=%b last=%b idx=%0d seq=%0d drop=%0d data=%0h, required all zero",
               tag, v_o, busy_o, last_o, idx_o, seq_o, drop_cnt_o, data_o);
    end
  endtask

  // Drains a full snapshot with ready held high, checking data = mul*k+add
  task automatic drain_all(input string tag, input int unsigned mul, input int unsigned add,
                           input logic [7:0] exp_seq);
    ready = 1'b1;
    for (int b = 0; b < int'(N); b++) begin
      checks++;
      if (v_o !== 1'b1 || idx_o !== IW'(b) || data_o !== W'(mul * b + add) ||
          seq_o !== exp_seq || last_o !== (b == int'(N) - 1)) begin
        errors++;
        $display("FAIL %s beat %0d: v=%b idx=%0d data=%0d seq=%0d last=%b, required v=1 idx=%0d data=%0d seq=%0d last=%b",
                 tag, b, v_o, idx_o, data_o, seq_o, last_o, b, mul * b + add, exp_seq, b == int'(N) - 1);
      end
      step();
    end
    checks++;
    if (v_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: v=%b busy=%b, required 0 0", tag, v_o, busy_o);
    end
  endtask

  task automatic test_reset();
    #3;
    check_reset_vals("reset_async");
    step();
    step();
    reset_n = 1'b1;
    step();
    check_reset_vals("reset_released");
  endtask

  task automatic test_single_drain();
    set_counters(3, 1);
    ready = 1'b1;
    step();
    checks++;
    if (v_o !== 1'b0 || idx_o !== '0) begin
      errors++;
      $display("FAIL ready_in_idle: v=%b idx=%0d, required 0 0", v_o, idx_o);
    end
    snapshot = 1'b1;
    step();
    snapshot = 1'b0;
    drain_all("single", 3, 1, 8'd1);
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_data [N];
    logic [W-1:0] prev_data;
    logic         stalled_prev;
    int           beat;
    int           stalls;
    bit           done;
    int unsigned  base;
    base = 1000;
    set_counters(1, base);
    for (int k = 0; k < int'(N); k++) exp_data[k] = W'(base + k);
    ready = 1'b0;
    snapshot = 1'b1;
    step();
    snapshot = 1'b0;
    beat = 0; stalls = 0; done = 0; stalled_prev = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      base++;
      set_counters(1, base);
      checks++;
      if (v_o !== 1'b1 || idx_o !== IW'(beat) || data_o !== exp_data[beat] ||
          seq_o !== 8'd2 || last_o !== (beat == int'(N) - 1)) begin
        errors++;
        $display("FAIL bp beat %0d: v=%b idx=%0d data=%0d seq=%0d last=%b, required v=1 idx=%0d data=%0d seq=2",
                 beat, v_o, idx_o, data_o, seq_o, last_o, beat, exp_data[beat]);
      end
      if (stalled_prev) begin
        checks++;
        if (data_o !== prev_data) begin
          errors++;
          $display("FAIL bp_stall_hold beat %0d: data=%0d, required %0d", beat, data_o, prev_data);
        end
      end
      prev_data = data_o;
      ready = 1'($urandom_range(0, 1));
      stalled_prev = !ready;
      if (ready) begin
        if (beat == int'(N) - 1) done = 1;
        beat++;
      end else begin
        stalls++;
      end
      step();
    end
    ready = 1'b0;
    checks++;
    if (!done || v_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete: done=%0d v=%b beats=%0d stalls=%0d, required done=1 v=0", done, v_o, beat, stalls);
    end
  endtask

  task automatic test_drop();
    set_counters(5, 7);
    ready = 1'b0;
    snapshot = 1'b1;
    step();
    for (int i = 0; i < 300; i++) step();
    snapshot = 1'b0;
    checks++;
    if (drop_cnt_o !== 8'd255 || v_o !== 1'b1 || idx_o !== '0 || data_o !== 32'd7 || seq_o !== 8'd3) begin
      errors++;
      $display("FAIL drop_sat: drop=%0d v=%b idx=%0d data=%0d seq=%0d, required 255 1 0 7 3",
               drop_cnt_o, v_o, idx_o, data_o, seq_o);
    end
    drain_all("drop_drain", 5, 7, 8'd3);
    checks++;
    if (drop_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL drop_hold: drop=%0d, required 255", drop_cnt_o);
    end
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_counters(3, 1);
    ready = 1'b1;
    snapshot = 1'b1;
    step();
    snapshot = 1'b0;
    for (int b = 0; b < int'(N); b++) begin
      checks++;
      if (v_o !== 1'b1 || idx_o !== IW'(b) || data_o !== W'(3 * b + 1)) begin
        errors++;
        $display("FAIL b2b_first beat %0d: v=%b idx=%0d data=%0d, required 1 %0d %0d", b, v_o, idx_o, data_o, b, 3 * b + 1);
      end
      if (b == int'(N) - 1) begin
        set_counters(11, 2);
        snapshot = 1'b1;
      end
      step();
    end
    snapshot = 1'b0;
    checks++;
    if (v_o !== 1'b1 || idx_o !== '0 || seq_o !== 8'd5 || data_o !== 32'd2 || drop_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL b2b_restart: v=%b idx=%0d seq=%0d data=%0d drop=%0d, required 1 0 5 2 255",
               v_o, idx_o, seq_o, data_o, drop_cnt_o);
    end
    drain_all("b2b_second", 11, 2, 8'd5);
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    set_counters(3, 1);
    ready = 1'b1;
    snapshot = 1'b1;
    step();
    snapshot = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (v_o !== 1'b1 || idx_o !== 5'd5 || seq_o !== 8'd6) begin
      errors++;
      $display("FAIL rst_mid_pre: v=%b idx=%0d seq=%0d, required 1 5 6", v_o, idx_o, seq_o);
    end
    run = 1'b0;
    #2;
    reset_n = 1'b0;
    #2;
    check_reset_vals("rst_mid_async");
    #2;
    reset_n = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (v_o !== 1'b0 || busy_o !== 1'b0 || seq_o !== 8'd0) begin
        errors++;
        $display("FAIL rst_mid_after cyc %0d: v=%b busy=%b seq=%0d, required 0 0 0", i, v_o, busy_o, seq_o);
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_seq_wrap();
    set_counters(2, 9);
    ready = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      snapshot = 1'b1;
      step();
      snapshot = 1'b0;
      if (n == 255 || n == 256) begin
        checks++;
        if (v_o !== 1'b1 || idx_o !== '0 || seq_o !== 8'(n)) begin
          errors++;
          $display("FAIL seq_wrap drain %0d: v=%b idx=%0d seq=%0d, required 1 0 %0d", n, v_o, idx_o, seq_o, n % 256);
        end
      end
      for (int b = 0; b < int'(N); b++) step();
    end
    checks++;
    if (v_o !== 1'b0 || seq_o !== 8'd0) begin
      errors++;
      $display("FAIL seq_wrap_end: v=%b seq=%0d, required 0 0", v_o, seq_o);
    end
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_mid_drain();
    test_seq_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_counter_snapshot_drain.md
BP_COUNTER_SNAPSHOT_DRAIN -- requirements
Module: bp_counter_snapshot_drain

Interface
REQ-001 SHALL have parameter width_p, default 32: width of each counter word.
REQ-002 SHALL have parameter els_p, default 22: number of counters in the bank; legal range 2..256.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port counters_i, input, els_p*width_p: flat live counter bank; counter k occupies bits [k*width_p +: width_p].
REQ-006 SHALL have port snapshot_v_i, input, 1: request to capture the bank, sampled each cycle.
REQ-007 SHALL have port v_o, output, 1: stream word valid.
REQ-008 SHALL have port ready_i, input, 1: downstream ready.
REQ-009 SHALL have port data_o, output, width_p: captured counter value.
REQ-010 SHALL have port idx_o, output, clog2(els_p): index of the counter in data_o.
REQ-011 SHALL have port seq_o, output, 8: sequence number of the snapshot being drained.
REQ-012 SHALL have port last_o, output, 1: high when idx_o == els_p-1 and v_o is high.
REQ-013 SHALL have port busy_o, output, 1: high while in DRAIN.
REQ-014 SHALL have port drop_cnt_o, output, 8: count of rejected snapshot requests.

Function
REQ-015 SHALL implement two states, IDLE and DRAIN.
REQ-016 SHALL, in IDLE with snapshot_v_i=1, copy all of counters_i into a shadow bank at that clock edge, set idx to 0, increment seq by 1, and enter DRAIN.
REQ-017 SHALL present v_o=1 with idx_o=0 and the shadow word 0 in the cycle after the request (1-cycle latency).
REQ-018 SHALL assert v_o only in DRAIN; v_o SHALL stay 1 until the final handshake.
REQ-019 SHALL treat v_o & ready_i as a handshake; each handshake advances idx by 1.
REQ-020 SHALL hold data_o, idx_o, seq_o and last_o stable while v_o=1 and ready_i=0.
REQ-021 SHALL source data_o only from the shadow bank; later changes on counters_i SHALL NOT affect a drain in progress.
REQ-022 SHALL, on the handshake with last_o=1, return to IDLE, so that busy_o and v_o are 0 in the next cycle.
REQ-023 SHALL, when snapshot_v_i=1 in the same cycle as the last handshake, accept the request as if in IDLE: recapture, set idx to 0, increment seq, and remain in DRAIN with no bubble.
REQ-024 SHALL, for snapshot_v_i=1 in DRAIN in any other cycle, drop the request, leave the state unchanged, and increment drop_cnt_o, saturating at 255.
REQ-025 SHALL let seq wrap from 255 to 0.
REQ-026 SHALL never drive an idx_o value at or above els_p.
REQ-027 SHALL allow ready_i to be asserted before v_o; ready_i has no effect in IDLE.
REQ-028 SHALL drive data_o, idx_o and seq_o from registers, with no combinational path from ready_i or snapshot_v_i to any output.

Reset
REQ-029 SHALL, while reset_n_i=0 and independent of clk_i, force: state=IDLE, v_o=0, busy_o=0, last_o=0, idx_o=0, seq_o=0, drop_cnt_o=0, data_o=0.
REQ-030 SHALL leave the shadow bank contents unspecified after reset; they SHALL NOT be observable until the next capture.
REQ-031 SHALL, on reset asserted mid-drain, abandon the drain with no further v_o, and resume normal operation on the first edge after deassertion.

Verification
REQ-032 SHALL cover single drain, els_p=22, width_p=32, ready_i held 1. Stimulus: counters_i[k]=k*3+1, one-cycle snapshot. Response: 22 beats on consecutive cycles, idx 0..21, data 1,4,...,64, seq_o=1, last_o only on beat 21, busy_o low one cycle after beat 21.
REQ-033 SHALL cover backpressure and isolation. Stimulus: ready_i toggled randomly while counters_i increments every cycle. Response: data_o equals the values captured at request time and is stable across every stalled cycle.
REQ-034 SHALL cover drop and saturation. Stimulus: 300 snapshot_v_i pulses during one long stalled drain. Response: drop_cnt_o=255; the drain completes unaffected.
REQ-035 SHALL cover back-to-back. Stimulus: snapshot_v_i in the cycle of the last handshake. Response: the next cycle shows idx_o=0 and seq_o incremented, with v_o never deasserting.
REQ-036 SHALL cover reset mid-drain. Stimulus: reset_n_i=0 at beat 5 with clock stopped. Response: outputs go to reset values immediately; after release with no request, v_o=0.
REQ-037 SHALL cover seq wrap. Stimulus: 256 completed snapshots. Response: seq_o reads 0 on the 256th drain.
